// File: rtl/win_checker_if.sv
// Handshake and board-memory read port of the win checker.
// The slave modport is the checker; the master modport is the game controller plus board memory.
interface win_checker_if #(
  parameter int N         = 15,
  parameter int CELL_BITS = 2,
  parameter int ABITS     = $clog2(N*N),
  parameter int RBITS     = $clog2(N)
);
  logic                 start;
  logic [RBITS-1:0]     row;
  logic [RBITS-1:0]     col;
  logic [CELL_BITS-1:0] player;
  logic                 busy;
  logic                 done;
  logic                 win;
  logic                 mem_ren;
  logic [ABITS-1:0]     mem_addr;
  logic [CELL_BITS-1:0] mem_dout;

  modport master (
    output start, row, col, player, mem_dout,
    input  busy, done, win, mem_ren, mem_addr
  );

  modport slave (
    input  start, row, col, player, mem_dout,
    output busy, done, win, mem_ren, mem_addr
  );
endinterface

// File: rtl/win_checker.sv
// Checks whether the stone just placed at (row,col) completes five or more in a line,
// walking outward in four directions and reading one board cell at a time.
//
// state | meaning
// IDLE  | waiting for start
// ADV   | form next candidate cell, or finish the current side/direction
// REQ   | read request for the candidate cell
// CMP   | compare returned cell with player
// FIN   | result valid, done pulse
module win_checker #(
  parameter int N         = 15,
  parameter int CELL_BITS = 2,
  parameter int ABITS     = $clog2(N*N)
) (
  input logic          clk,
  input logic          rst,
  win_checker_if.slave bus
);
  localparam int RBITS = $clog2(N);
  localparam int SW    = RBITS + 4;

  localparam logic signed [SW-1:0] P1   = SW'(1);
  localparam logic signed [SW-1:0] Z0   = '0;
  localparam logic signed [SW-1:0] N_S  = SW'(N);
  localparam logic [RBITS:0]       N_U  = (RBITS+1)'(N);
  localparam logic [ABITS-1:0]     N_A  = ABITS'(N);

  typedef enum logic [2:0] {S_IDLE, S_ADV, S_REQ, S_CMP, S_FIN} state_t;

  state_t               state;
  logic [RBITS-1:0]     c_row;
  logic [RBITS-1:0]     c_col;
  logic [CELL_BITS-1:0] plyr;
  logic [1:0]           dir;
  logic                 side;
  logic [2:0]           step;
  logic [2:0]           cnt;
  logic                 busy_r;
  logic                 done_r;
  logic                 win_r;
  logic                 ren_r;
  logic [ABITS-1:0]     addr_r;

  logic signed [SW-1:0] dr;
  logic signed [SW-1:0] dc;
  logic signed [SW-1:0] k;
  logic signed [SW-1:0] cr;
  logic signed [SW-1:0] cc;
  logic                 on_board;
  logic [ABITS-1:0]     cand_addr;
  logic [2:0]           nxt_cnt;
  logic                 start_ok;

  always_comb begin
    dr = Z0;
    dc = Z0;
    unique case (dir)
      2'd0: begin dr = Z0; dc = P1;  end
      2'd1: begin dr = P1; dc = Z0;  end
      2'd2: begin dr = P1; dc = P1;  end
      2'd3: begin dr = P1; dc = -P1; end
    endcase
    if (side) begin
      dr = -dr;
      dc = -dc;
    end
    k  = $signed(SW'(step)) + P1;
    cr = $signed(SW'(c_row)) + k * dr;
    cc = $signed(SW'(c_col)) + k * dc;
    on_board = !cr[SW-1] && (cr < N_S) && !cc[SW-1] && (cc < N_S);
    // Only in-range coordinates ever reach the multiplier.
    cand_addr = '0;
    if (on_board)
      cand_addr = ABITS'(cr[RBITS-1:0]) * N_A + ABITS'(cc[RBITS-1:0]);
    nxt_cnt  = cnt + 3'd1;
    start_ok = (bus.player != '0) && ({1'b0, bus.row} < N_U) && ({1'b0, bus.col} < N_U);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      c_row  <= '0;
      c_col  <= '0;
      plyr   <= '0;
      dir    <= '0;
      side   <= 1'b0;
      step   <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      win_r  <= 1'b0;
      ren_r  <= 1'b0;
      addr_r <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            c_row  <= bus.row;
            c_col  <= bus.col;
            plyr   <= bus.player;
            dir    <= '0;
            side   <= 1'b0;
            step   <= '0;
            cnt    <= 3'd1;
            win_r  <= 1'b0;
            busy_r <= 1'b1;
            if (start_ok) begin
              state <= S_ADV;
            end else begin
              state  <= S_FIN;
              done_r <= 1'b1;
            end
          end
        end
        S_ADV: begin
          if (step < 3'd4 && on_board) begin
            state  <= S_REQ;
            ren_r  <= 1'b1;
            addr_r <= cand_addr;
          end else if (!side) begin
            side <= 1'b1;
            step <= '0;
          end else if (dir == 2'd3) begin
            state  <= S_FIN;
            done_r <= 1'b1;
            win_r  <= 1'b0;
          end else begin
            dir  <= dir + 2'd1;
            side <= 1'b0;
            step <= '0;
            cnt  <= 3'd1;
          end
        end
        S_REQ: begin
          state  <= S_CMP;
          ren_r  <= 1'b0;
          addr_r <= '0;
        end
        S_CMP: begin
          if (bus.mem_dout == plyr) begin
            cnt  <= nxt_cnt;
            step <= step + 3'd1;
            // Stop at five so overlines need no extra count width.
            if (nxt_cnt >= 3'd5) begin
              state  <= S_FIN;
              done_r <= 1'b1;
              win_r  <= 1'b1;
            end else begin
              state <= S_ADV;
            end
          end else begin
            step  <= 3'd4;
            state <= S_ADV;
          end
        end
        S_FIN: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          ren_r  <= 1'b0;
          addr_r <= '0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.win      = win_r;
  assign bus.mem_ren  = ren_r;
  assign bus.mem_addr = addr_r;
endmodule

// File: tb/tb_win_checker.sv
// Bench for win_checker: directed board patterns plus random boards, checked against
// a line-counting reference model and a registered board-memory model.
module tb_win_checker;
  localparam int N  = 15;
  localparam int CB = 2;
  localparam int AB = $clog2(N*N);
  localparam int RB = $clog2(N);

  logic clk = 1'b0;
  logic rst;

  win_checker_if #(.N(N), .CELL_BITS(CB), .ABITS(AB), .RBITS(RB)) bus ();

  win_checker #(.N(N), .CELL_BITS(CB), .ABITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [CB-1:0] board [0:N*N-1];
  int vectors     = 0;
  int miscompares = 0;
  int reads[$];
  int done_cnt  = 0;
  int bad_addr  = 0;
  int bad_ren   = 0;
  int bad_leak  = 0;
  int exp_reads[$];
  logic exp_win;

  // Registered board memory: data valid the cycle after mem_ren.
  always @(posedge clk) begin
    if (rst) bus.mem_dout <= '0;
    else if (bus.mem_ren) bus.mem_dout <= board[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (bus.mem_ren) begin
        reads.push_back(int'(bus.mem_addr));
        if (int'(bus.mem_addr) >= N*N) bad_addr++;
        if (!bus.busy) bad_ren++;
      end else if (bus.mem_addr != '0) begin
        bad_leak++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk each line outward from the centre, stop a side at the edge or the
  // first foreign cell, and declare a win as soon as five stones are seen.
  task automatic model(input int r, input int c, input int p);
    int drs[4] = '{0, 1, 1, 1};
    int dcs[4] = '{1, 0, 1, -1};
    int total;
    int rr;
    int cc;
    exp_reads.delete();
    exp_win = 1'b0;
    if (p == 0 || r >= N || c >= N) return;
    for (int d = 0; d < 4; d++) begin
      total = 1;
      for (int s = 0; s < 2; s++) begin
        for (int kk = 1; kk <= 4; kk++) begin
          rr = r + (s == 0 ? kk : -kk) * drs[d];
          cc = c + (s == 0 ? kk : -kk) * dcs[d];
          if (rr < 0 || rr >= N || cc < 0 || cc >= N) break;
          exp_reads.push_back(rr * N + cc);
          if (int'(board[rr * N + cc]) != p) break;
          total++;
          if (total >= 5) begin
            exp_win = 1'b1;
            return;
          end
        end
      end
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < N*N; i++) board[i] = '0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 200) begin @(negedge clk); t++; end
  endtask

  task automatic run_scan(input int r, input int c, input int p, input bit poke, input string tag);
    int base;
    int dbase;
    int lat;
    int n_got;
    bit ok;
    wait_idle();
    model(r, c, p);
    @(negedge clk);
    base  = reads.size();
    dbase = done_cnt;
    bus.start  = 1'b1;
    bus.row    = RB'(r);
    bus.col    = RB'(c);
    bus.player = CB'(p);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 3) begin
        bus.start  = 1'b1;
        bus.row    = RB'($urandom_range(0, N-1));
        bus.col    = RB'($urandom_range(0, N-1));
        bus.player = CB'($urandom_range(1, 2));
      end
      if (lat == 5) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk({tag, " latency<=74"}, 32'(lat <= 74), 1);
    chk({tag, " win"}, 32'(bus.win), 32'(exp_win));
    @(negedge clk);
    chk({tag, " busy_after"}, 32'(bus.busy), 0);
    chk({tag, " win_held"}, 32'(bus.win), 32'(exp_win));
    chk({tag, " done_pulses"}, 32'(done_cnt - dbase), 1);
    n_got = reads.size() - base;
    chk({tag, " read_count"}, 32'(n_got), 32'(exp_reads.size()));
    ok = 1'b1;
    for (int i = 0; i < n_got && i < exp_reads.size(); i++)
      if (reads[base + i] != exp_reads[i]) ok = 1'b0;
    chk({tag, " read_addrs"}, 32'(ok), 1);
  endtask

  initial begin
    int r;
    int c;
    int p;
    int len;
    int d;
    int t;
    bit found;
    int ldr[4] = '{0, 1, 1, 1};
    int ldc[4] = '{1, 0, 1, -1};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.row    = '0;
    bus.col    = '0;
    bus.player = '0;
    clear_board();
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset win", 32'(bus.win), 0);
    chk("reset mem_ren", 32'(bus.mem_ren), 0);
    chk("reset mem_addr", 32'(bus.mem_addr), 0);
    rst = 1'b0;

    // Five in a row centred on the placed stone, early exit on the last read.
    for (int i = 3; i <= 7; i++) board[7*N + i] = 2'b01;
    run_scan(7, 5, 1, 1'b0, "row5");
    chk("row5 first_read", 32'(reads.size() >= 5 ? reads[reads.size()-5] : -1), 32'(7*N + 6));

    clear_board();
    for (int i = 3; i <= 6; i++) board[7*N + i] = 2'b01;
    run_scan(7, 6, 1, 1'b0, "row4");

    clear_board();
    run_scan(0, 0, 2, 1'b0, "corner");
    run_scan(14, 14, 1, 1'b0, "far_corner");

    for (int i = 2; i <= 8; i++) board[i*N + i] = 2'b10;
    run_scan(5, 5, 2, 1'b0, "diag_w");
    run_scan(5, 5, 1, 1'b0, "diag_b");
    run_scan(5, 5, 2, 1'b1, "diag_poke");

    // Six in an anti-diagonal still wins.
    clear_board();
    for (int i = 0; i < 6; i++) board[(4 + i)*N + (10 - i)] = 2'b01;
    run_scan(6, 8, 1, 1'b0, "overline");

    run_scan(7, 7, 0, 1'b0, "player0");
    run_scan(15, 3, 1, 1'b0, "row_oob");
    run_scan(3, 15, 2, 1'b0, "col_oob");

    // Reset landing on a read cycle.
    clear_board();
    for (int i = 3; i <= 7; i++) board[7*N + i] = 2'b01;
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.row = RB'(7); bus.col = RB'(5); bus.player = CB'(1);
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    t = 0;
    while (!found && t < 50) begin
      if (bus.mem_ren) found = 1'b1;
      else begin @(negedge clk); t++; end
    end
    chk("rst_mid reached_req", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid busy", 32'(bus.busy), 0);
    chk("rst_mid done", 32'(bus.done), 0);
    chk("rst_mid win", 32'(bus.win), 0);
    chk("rst_mid mem_ren", 32'(bus.mem_ren), 0);
    chk("rst_mid mem_addr", 32'(bus.mem_addr), 0);
    rst = 1'b0;
    run_scan(7, 5, 1, 1'b0, "after_rst");

    // Reset and start together: start is dropped.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.row = RB'(7); bus.col = RB'(5); bus.player = CB'(1);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_start busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("rst_start busy2", 32'(bus.busy), 0);
    chk("rst_start done", 32'(bus.done), 0);

    // Random boards, biased toward the scanning player, often with a planted line.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, N-1);
      c = $urandom_range(0, N-1);
      p = $urandom_range(1, 2);
      if ($urandom_range(0, 9) == 0) r = $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) p = $urandom_range(0, 3);
      for (int i = 0; i < N*N; i++) begin
        t = $urandom_range(0, 9);
        board[i] = (t < 4) ? CB'(p) : (t < 6) ? CB'(3 - p) : '0;
      end
      if ($urandom_range(0, 1) == 1 && r < N) begin
        d = $urandom_range(0, 3);
        len = $urandom_range(2, 5);
        for (int kk = -len; kk <= len; kk++) begin
          if (r + kk*ldr[d] >= 0 && r + kk*ldr[d] < N && c + kk*ldc[d] >= 0 && c + kk*ldc[d] < N)
            board[(r + kk*ldr[d])*N + c + kk*ldc[d]] = CB'(p);
        end
      end
      run_scan(r, c, p, ($urandom_range(0, 3) == 0) && p != 0 && r < N, "rand");
    end

    chk("offboard_addr", 32'(bad_addr), 0);
    chk("ren_while_idle", 32'(bad_ren), 0);
    chk("addr_outside_req", 32'(bad_leak), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/win_checker.md
WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 Parameter N, default 15, SHALL set board side length in cells.
REQ-002 Parameter CELL_BITS, default 2, SHALL set bits per cell: 00 empty, 01 black, 10 white.
REQ-003 Parameter ABITS, default $clog2(N*N), SHALL set memory address width; RBITS = $clog2(N).
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 start  input  1  SHALL request a scan around the just-placed stone.
REQ-007 row, col  input  RBITS each  SHALL give the placed cell, sampled on start acceptance.
REQ-008 player  input  CELL_BITS  SHALL give the stone value to match, sampled on start acceptance.
REQ-009 busy  output  1  SHALL be high in every non-IDLE state.
REQ-010 done  output  1  SHALL be a one-cycle pulse when the result is valid.
REQ-011 win  output  1  SHALL be the result: five or more in a line.
REQ-012 mem_ren  output  1  SHALL drive the board memory read enable.
REQ-013 mem_addr  output  ABITS  SHALL drive the board memory address: row*N+col.
REQ-014 mem_dout  input  CELL_BITS  SHALL be board memory read data, valid the cycle after mem_ren.

Function
REQ-015 States SHALL be IDLE, ADV, REQ, CMP, FIN.
REQ-016 IDLE: start=1 SHALL latch row/col/player, set dir=0, side=+, step=0, cnt=1, clear win, go ADV.
REQ-017 start while busy SHALL be ignored; start with player=00 or row/col >= N SHALL go directly to FIN with win=0, no reads.
REQ-018 Directions: dir 0 (0,+1), 1 (+1,0), 2 (+1,+1), 3 (+1,-1) as (drow,dcol); side - negates delta.
REQ-019 ADV: candidate = centre + (step+1)*delta; if step<4 and candidate on-board -> REQ; else end side.
REQ-020 End side: if side=+ -> side=-, step=0, stay ADV; if side=- -> dir++, side=+, step=0, cnt=1, stay ADV, or FIN with win=0 if dir=3.
REQ-021 REQ: mem_ren=1 and mem_addr=candidate for exactly one cycle -> CMP.
REQ-022 CMP: mem_dout==player -> cnt++, step++; if new cnt>=5 -> FIN with win=1 (early exit), else ADV; mismatch -> step=4, ADV.
REQ-023 Centre cell SHALL never be read; it counts as 1.
REQ-024 cnt SHALL be 3 bits; overlines (6+) SHALL count as win.
REQ-025 FIN: done=1 one cycle -> IDLE; win SHALL hold until next accepted start.
REQ-026 mem_ren SHALL be 0 outside REQ; mem_addr SHALL be 0 outside REQ.
REQ-027 Off-board addresses SHALL never be driven; row/col arithmetic SHALL bounds-check before multiply.
REQ-028 Block SHALL never write memory; the integrating writer SHALL not assert wen while busy=1.
REQ-029 Worst-case latency start->done SHALL be <= 4*(2*4*2+2)+2 = 74 cycles.

Reset
REQ-030 rst=1 SHALL force state IDLE, busy=0, done=0, win=0, mem_ren=0, mem_addr=0 on the next edge, overriding any state including mid-scan.
REQ-031 rst and start in the same cycle SHALL leave the block in IDLE with start ignored.

Verification
REQ-032 Player 01 at (7,3..7), start (7,5) player 01 -> reads (7,6),(7,7),(7,8),(7,4),(7,3); done=1, win=1 after the (7,3) CMP; no further reads.
REQ-033 Player 01 at (7,3..6), start (7,6) player 01 -> all 4 directions scanned, done pulses once, win=0.
REQ-034 Empty board, start (0,0) player 10 -> no mem_addr with row or col outside 0..14 during mem_ren, win=0.
REQ-035 Player 10 at (2..8,2..8) diagonal, start (5,5) player 10 -> win=1; same board, player 01 -> win=0.
REQ-036 rst pulsed during a REQ cycle -> next cycle busy=0, done=0, win=0, mem_ren=0; new start then runs normally.
REQ-037 start reasserted while busy -> ignored; exactly one done pulse per accepted start.
